// File: rtl/squeezer_apply_pkg.sv
// squeezer_apply_pkg: rule-code constants and helpers shared by the squeezer rule logic and apply stage
package squeezer_apply_pkg;
  localparam int RULE_W = 3;
  localparam logic [RULE_W-1:0] RULE_NONE = 3'd0;
  localparam logic [RULE_W-1:0] RULE_1    = 3'd1;
  localparam logic [RULE_W-1:0] RULE_2    = 3'd2;
  localparam logic [RULE_W-1:0] RULE_3    = 3'd3;
  localparam logic [RULE_W-1:0] RULE_4    = 3'd4;
  localparam logic [RULE_W-1:0] RULE_5    = 3'd5;
  function automatic logic rule_illegal(input logic [RULE_W-1:0] r);
    return r > RULE_5;
  endfunction
endpackage

// File: rtl/squeezer_apply_csa32.sv
// squeezer_apply_csa32: N-bit 3:2 compressor returning sum, shifted carry and the carry lost off the top
module squeezer_apply_csa32 #(
  parameter int N = 1 << 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [N-1:0] c_i,
  output logic [N-1:0] s_o,
  output logic [N-1:0] c_o,
  output logic         ovf_o
);
  logic [N-1:0] m;
  assign m     = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign s_o   = a_i ^ b_i ^ c_i;
  assign c_o   = {m[N-2:0], 1'b0};
  assign ovf_o = m[N-1];
endmodule

// File: rtl/squeezer_apply.sv
// squeezer_apply: adds the rule-selected modulus multiple to a carry-save pair through a 2-stage pipeline
module squeezer_apply
  import squeezer_apply_pkg::*;
#(
  parameter int N = 1 << 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      p_in,
  input  logic [N-1:0]      q_in,
  input  logic [RULE_W-1:0] rule,
  input  logic              k_we,
  input  logic [RULE_W-1:0] k_addr,
  input  logic [N-1:0]      k_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      p_out,
  output logic [N-1:0]      q_out,
  output logic              ovf,
  output logic              rule_err
);
  logic         adv, acc;
  logic         v1_q, v2_q, ovf_q, err_q, err_d;
  logic [N-1:0] p1_q, q1_q, k1_q, po_q, qo_q;
  logic [N-1:0] k_sel, s, c;
  logic         c_ovf;
  logic [N-1:0] k_q [1:5];

  assign adv       = !v2_q || out_ready;
  assign acc       = in_valid && adv;
  assign in_ready  = adv;
  assign out_valid = v2_q;
  assign p_out     = po_q;
  assign q_out     = qo_q;
  assign ovf       = ovf_q;
  assign rule_err  = err_q;
  assign err_d     = err_q || (acc && rule_illegal(rule));

  // Constant lookup; rule 0 and the illegal codes fall through to zero
  always_comb begin
    k_sel = '0;
    for (int i = 1; i <= 5; i++)
      if (rule == 3'(i)) k_sel = k_q[i];
  end

  // Constant bank; only indices 1..5 exist, other addresses are dropped
  always_ff @(posedge clk) begin
    for (int i = 1; i <= 5; i++)
      if (rst) k_q[i] <= '0;
      else if (k_we && k_addr == 3'(i)) k_q[i] <= k_data;
  end

  squeezer_apply_csa32 #(.N(N)) u_csa (
    .a_i  (p1_q),
    .b_i  (q1_q),
    .c_i  (k1_q),
    .s_o  (s),
    .c_o  (c),
    .ovf_o(c_ovf)
  );

  // Two-stage pipeline that advances as a whole whenever the output slot frees up
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      p1_q  <= '0;
      q1_q  <= '0;
      k1_q  <= '0;
      po_q  <= '0;
      qo_q  <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (adv) begin
        v1_q <= in_valid;
        v2_q <= v1_q;
        if (in_valid) begin
          p1_q <= p_in;
          q1_q <= q_in;
          k1_q <= k_sel;
        end
        if (v1_q) begin
          po_q  <= s;
          qo_q  <= c;
          ovf_q <= c_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_squeezer_apply.sv
// tb_squeezer_apply: directed and random-handshake checks of the squeezer apply pipeline at N=8
module tb_squeezer_apply;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, k_we, out_valid, out_ready, ovf, rule_err;
  logic [N-1:0] p_in, q_in, k_data, p_out, q_out;
  logic [2:0]   rule, k_addr;
  int           n_cmp = 0;
  int           n_err = 0;

  squeezer_apply #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p_in(p_in), .q_in(q_in), .rule(rule), .k_we(k_we), .k_addr(k_addr),
    .k_data(k_data), .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .q_out(q_out), .ovf(ovf), .rule_err(rule_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic kwrite(input logic [2:0] a, input logic [N-1:0] d);
    k_we = 1'b1; k_addr = a; k_data = d;
    tick;
    k_we = 1'b0;
  endtask

  task automatic send1(input logic [N-1:0] p, input logic [N-1:0] q, input logic [2:0] r);
    in_valid = 1'b1; p_in = p; q_in = q; rule = r;
    tick;
    in_valid = 1'b0;
  endtask

  logic [N-1:0] kb [8];
  logic [N-1:0] qp[$], qq[$], qs[$];
  logic         qo[$];

  initial begin
    logic [N-1:0] ep, eq, ek, em, sum_o;
    int sent, got;
    rst = 1'b1; in_valid = 1'b0; p_in = '0; q_in = '0; rule = '0;
    k_we = 1'b0; k_addr = '0; k_data = '0; out_ready = 1'b1;
    tick; tick;
    rst = 1'b0;
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_in_ready",  16'(in_ready),  16'd1);
    chk("rst_rule_err",  16'(rule_err),  16'd0);
    chk("rst_p_out",     16'(p_out),     16'd0);
    chk("rst_q_out",     16'(q_out),     16'd0);
    chk("rst_ovf",       16'(ovf),       16'd0);

    kwrite(3'd2, 8'h35);
    send1(8'h0F, 8'hF0, 3'd2);
    chk("lat1_out_valid", 16'(out_valid), 16'd0);
    tick;
    chk("t1_out_valid", 16'(out_valid), 16'd1);
    chk("t1_p_out",     16'(p_out),     16'h00CA);
    chk("t1_q_out",     16'(q_out),     16'h006A);
    chk("t1_ovf",       16'(ovf),       16'd0);
    tick;
    chk("t1_drained", 16'(out_valid), 16'd0);

    send1(8'h80, 8'h80, 3'd0);
    tick;
    chk("t2_p_out", 16'(p_out), 16'h0000);
    chk("t2_q_out", 16'(q_out), 16'h0000);
    chk("t2_ovf",   16'(ovf),   16'd1);
    tick;

    kwrite(3'd3, 8'h11);
    k_we = 1'b1; k_addr = 3'd3; k_data = 8'h22;
    in_valid = 1'b1; p_in = '0; q_in = '0; rule = 3'd3;
    tick;
    k_we = 1'b0;
    tick;
    in_valid = 1'b0;
    chk("kwr_old_p_out", 16'(p_out), 16'h0011);
    chk("kwr_old_q_out", 16'(q_out), 16'h0000);
    tick;
    chk("kwr_new_p_out", 16'(p_out), 16'h0022);
    tick;

    chk("err_before", 16'(rule_err), 16'd0);
    send1(8'h01, 8'h02, 3'd7);
    chk("err_rise", 16'(rule_err), 16'd1);
    tick;
    chk("r7_out_valid", 16'(out_valid), 16'd1);
    chk("r7_p_out",     16'(p_out),     16'h0003);
    chk("r7_q_out",     16'(q_out),     16'h0000);
    send1(8'h10, 8'h01, 3'd0);
    tick;
    chk("legal_after_err_p_out", 16'(p_out), 16'h0011);
    chk("err_sticky", 16'(rule_err), 16'd1);
    tick;

    out_ready = 1'b0;
    in_valid = 1'b1; p_in = 8'h01; q_in = 8'h01; rule = 3'd0;
    tick;
    p_in = 8'h02; q_in = 8'h02;
    tick;
    in_valid = 1'b0;
    chk("stall_out_valid", 16'(out_valid), 16'd1);
    chk("stall_in_ready",  16'(in_ready),  16'd0);
    chk("stall_p_out",     16'(p_out),     16'h0000);
    chk("stall_q_out",     16'(q_out),     16'h0002);
    tick;
    chk("stall_hold_q_out",    16'(q_out),    16'h0002);
    chk("stall_hold_in_ready", 16'(in_ready), 16'd0);
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 16'(in_ready), 16'd1);
    tick;
    chk("stall_t2_q_out", 16'(q_out), 16'h0004);
    tick;
    chk("bubble_out_valid", 16'(out_valid), 16'd0);

    kwrite(3'd1, 8'h5A);
    kwrite(3'd4, 8'hC3);
    kwrite(3'd5, 8'hFF);
    kb = '{8'h00, 8'h5A, 8'h35, 8'h22, 8'hC3, 8'hFF, 8'h00, 8'h00};
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; p_in = N'($urandom); q_in = N'($urandom); rule = 3'($urandom_range(0, 7));
      end else in_valid = 1'b0;
      #1;
      chk("rnd_in_ready", 16'(in_ready), 16'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        ek = kb[rule];
        em = (p_in & q_in) | (p_in & ek) | (q_in & ek);
        qp.push_back(p_in ^ q_in ^ ek);
        qq.push_back({em[N-2:0], 1'b0});
        qo.push_back(em[N-1]);
        qs.push_back(p_in + q_in + ek);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (qp.size() == 0) chk("rnd_spurious_output", 16'd1, 16'd0);
        else begin
          ep = qp.pop_front(); eq = qq.pop_front();
          chk("rnd_p_out", 16'(p_out), 16'(ep));
          chk("rnd_q_out", 16'(q_out), 16'(eq));
          chk("rnd_ovf",   16'(ovf),   16'(qo.pop_front()));
          sum_o = p_out + q_out;
          chk("rnd_invariant", 16'(sum_o), 16'(qs.pop_front()));
        end
        got++;
      end
      tick;
    end
    in_valid = 1'b0;
    chk("rnd_count", 16'(got), 16'd20);
    out_ready = 1'b1;
    tick; tick;
    chk("rnd_no_dup", 16'(out_valid), 16'd0);

    out_ready = 1'b0;
    in_valid = 1'b1; p_in = 8'h33; q_in = 8'h44; rule = 3'd1;
    tick; tick;
    chk("full_before_rst", 16'(out_valid), 16'd1);
    rst = 1'b1; k_we = 1'b1; k_addr = 3'd1; k_data = 8'h77;
    tick;
    rst = 1'b0; k_we = 1'b0; in_valid = 1'b0;
    chk("rst2_out_valid", 16'(out_valid), 16'd0);
    chk("rst2_in_ready",  16'(in_ready),  16'd1);
    chk("rst2_rule_err",  16'(rule_err),  16'd0);
    out_ready = 1'b1;
    send1(8'h01, 8'h00, 3'd1);
    tick;
    chk("rst2_k_cleared_valid", 16'(out_valid), 16'd1);
    chk("rst2_k_cleared_p_out", 16'(p_out),     16'h0001);
    chk("rst2_k_cleared_q_out", 16'(q_out),     16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
